// File: rtl/timer_prescaler_if.sv
// Tick interface between the timer prescaler (master) and the timer counter (slave).
// The master drives clk_ena and cks_active; the slave side provides the control inputs.
interface timer_prescaler_if;
   logic       run;
   logic [1:0] cks;
   logic       sync_clr;
   logic       clk_ena;
   logic [1:0] cks_active;

   modport master (
      input  run,
      input  cks,
      input  sync_clr,
      output clk_ena,
      output cks_active
   );

   modport slave (
      output run,
      output cks,
      output sync_clr,
      input  clk_ena,
      input  cks_active
   );
endinterface

// File: rtl/timer_prescaler.sv
// Clock-enable generator for the 8-bit timer: divides clk by 2/4/8/16 into a one-cycle strobe.
// Optional external tick source is compiled in with PRESCALER_EXT_CLK_EN.
module timer_prescaler (
   input  logic                      clk,
   input  logic                      rst,
`ifdef PRESCALER_EXT_CLK_EN
   input  logic                      ext_clk,
   input  logic                      ext_sel,
`endif
   timer_prescaler_if.master         bus
);

   logic [3:0] div_q, div_d;
   logic [1:0] sel_q, sel_d;
   logic       ena_q, ena_d;
   logic [3:0] mask;
   logic       match;

   // Low sel_q+1 bits of the divider all ones marks the last cycle of the period.
   assign mask  = {(sel_q == 2'd3), sel_q[1], |sel_q, 1'b1};
   assign match = ((div_q & mask) == mask);

`ifdef PRESCALER_EXT_CLK_EN
   logic sync1_q, sync2_q, ext_d_q;
   logic ext_sel_q, ext_sel_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         ext_d_q <= 1'b0;
      end else begin
         sync1_q <= ext_clk;
         sync2_q <= sync1_q;
         ext_d_q <= sync2_q;
      end
   end
`endif

   always_comb begin
      div_d = div_q;
      sel_d = sel_q;
      ena_d = 1'b0;
`ifdef PRESCALER_EXT_CLK_EN
      ext_sel_d = ext_sel_q;
`endif
      if (bus.sync_clr) begin
         div_d = 4'd0;
         sel_d = bus.cks;
`ifdef PRESCALER_EXT_CLK_EN
         ext_sel_d = ext_sel;
`endif
      end else if (!bus.run) begin
         sel_d = bus.cks;
`ifdef PRESCALER_EXT_CLK_EN
         ext_sel_d = ext_sel;
`endif
      end else begin
         div_d = div_q + 4'd1;
         ena_d = match;
         // Selection only switches at the common wrap so no period is ever shortened.
         if (div_q == 4'hF) begin
            sel_d = bus.cks;
`ifdef PRESCALER_EXT_CLK_EN
            ext_sel_d = ext_sel;
`endif
         end
`ifdef PRESCALER_EXT_CLK_EN
         if (ext_sel_q) begin
            ena_d = sync2_q & ~ext_d_q;
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= 4'd0;
         sel_q <= 2'd0;
         ena_q <= 1'b0;
      end else begin
         div_q <= div_d;
         sel_q <= sel_d;
         ena_q <= ena_d;
      end
   end

`ifdef PRESCALER_EXT_CLK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ext_sel_q <= 1'b0;
      end else begin
         ext_sel_q <= ext_sel_d;
      end
   end
`endif

   assign bus.clk_ena    = ena_q;
   assign bus.cks_active = sel_q;

endmodule

// File: tb/tb_timer_prescaler.sv
// Directed bench for timer_prescaler: a period-based reference model pushes expected
// outputs per clock into a scoreboard queue, popped and compared after each edge.
module tb_timer_prescaler;

   logic clk;
   logic rst;
`ifdef PRESCALER_EXT_CLK_EN
   logic ext_clk;
   logic ext_sel;
`endif

   timer_prescaler_if bus ();

   timer_prescaler dut (
      .clk     (clk),
      .rst     (rst),
`ifdef PRESCALER_EXT_CLK_EN
      .ext_clk (ext_clk),
      .ext_sel (ext_sel),
`endif
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       ena;
      logic [1:0] act;
   } exp_t;

   exp_t sb_q[$];

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int m_cnt    = 0;
   int m_sel    = 0;
   int pulses   = 0;
   logic last_exp_ena = 1'b0;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: pulse on the last cycle of each 2^(sel+1) period, counted from a clear.
   task automatic step(input string tag);
      exp_t e;
      exp_t got;
      e.ena = 1'b0;
      if (rst) begin
         m_cnt = 0;
         m_sel = 0;
      end else if (bus.sync_clr) begin
         m_cnt = 0;
         m_sel = int'(bus.cks);
      end else if (!bus.run) begin
         m_sel = int'(bus.cks);
      end else begin
         e.ena = (((m_cnt + 1) % (2 << m_sel)) == 0);
         if (m_cnt == 15) m_sel = int'(bus.cks);
         m_cnt = (m_cnt + 1) % 16;
      end
      e.act = 2'(m_sel);
      sb_q.push_back(e);
      last_exp_ena = e.ena;
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 4'd1, 4'd0);
      end else begin
         got = sb_q.pop_front();
         check({tag, "_ena"}, {3'd0, bus.clk_ena}, {3'd0, got.ena});
         check({tag, "_act"}, {2'd0, bus.cks_active}, {2'd0, got.act});
         if (bus.clk_ena === 1'b1) pulses++;
      end
   endtask

   initial begin
      rst          = 1'b1;
      bus.run      = 1'b1;
      bus.cks      = 2'b11;
      bus.sync_clr = 1'b0;
`ifdef PRESCALER_EXT_CLK_EN
      ext_clk = 1'b0;
      ext_sel = 1'b0;
`endif
      #1;
      check("reset_ena", {3'd0, bus.clk_ena}, 4'd0);
      check("reset_act", {2'd0, bus.cks_active}, 4'd0);
      for (int i = 0; i < 3; i++) step("in_reset");

      // /2 from reset
      bus.cks = 2'b00;
      rst     = 1'b0;
      for (int i = 0; i < 8; i++) step("div2");

      // /16 sweep: load select immediately via a clear, then 64 clocks
      bus.cks      = 2'b11;
      bus.sync_clr = 1'b1;
      step("clr16");
      bus.sync_clr = 1'b0;
      pulses       = 0;
      for (int i = 0; i < 64; i++) step("div16");
      check("div16_pulses", 4'(pulses), 4'd4);

      // Deferred select change mid-period
      for (int i = 0; i < 20 && m_cnt != 5; i++) step("to5");
      bus.cks = 2'b00;
      for (int i = 0; i < 24; i++) step("defer");

      // sync_clr at /4 while div_cnt = 3
      bus.cks      = 2'b01;
      bus.sync_clr = 1'b1;
      step("clr4");
      bus.sync_clr = 1'b0;
      for (int i = 0; i < 20 && m_cnt != 3; i++) step("to3");
      bus.sync_clr = 1'b1;
      step("clr_mid");
      bus.sync_clr = 1'b0;
      for (int i = 0; i < 10; i++) step("after_clr");

      // Hold at div_cnt = 6 for 10 cycles, then resume
      for (int i = 0; i < 20 && m_cnt != 6; i++) step("to6");
      bus.run = 1'b0;
      for (int i = 0; i < 10; i++) step("hold");
      bus.run = 1'b1;
      for (int i = 0; i < 20 && !last_exp_ena; i++) step("resume");
      check("pre_rst_ena", {3'd0, bus.clk_ena}, 4'd1);

      // Asynchronous reset while the strobe is high
      rst = 1'b1;
      #1;
      check("async_rst_ena", {3'd0, bus.clk_ena}, 4'd0);
      check("async_rst_act", {2'd0, bus.cks_active}, 4'd0);
      for (int i = 0; i < 2; i++) step("rst_hold");
      bus.cks = 2'b00;
      rst     = 1'b0;
      for (int i = 0; i < 6; i++) step("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
